// File: rtl/inst_fmt_pkg.sv
// Shared definitions for the instruction stream writer: format codes, MIPS field
// bit positions and writer FSM states.
package inst_fmt_pkg;

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_J    = 3'd2;
   localparam logic [2:0] FMT_CODE = 3'd3;
   localparam logic [2:0] FMT_COP  = 3'd4;

   localparam int unsigned OP_LSB   = 26;
   localparam int unsigned RS_LSB   = 21;
   localparam int unsigned RT_LSB   = 16;
   localparam int unsigned RD_LSB   = 11;
   localparam int unsigned SA_LSB   = 6;
   localparam int unsigned CODE_LSB = 6;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } wr_state_e;

   function automatic logic fmt_legal(input logic [2:0] fmt);
      return fmt <= FMT_COP;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers; push and pop may occur in the same
// cycle. Read data is the current head, valid whenever empty_o is low.
module sync_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW + 1)'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/inst_stream_writer.sv
// Packs MIPS field bundles into 32-bit words and streams them into instruction RAM at
// consecutive addresses. Define INST_WRITER_CHECKSUM_EN to add the checksum_o port.
module inst_stream_writer
   import inst_fmt_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              in_last_i,
   input  logic [2:0]        in_fmt_i,
   input  logic [5:0]        in_opcode_i,
   input  logic [4:0]        in_rs_i,
   input  logic [4:0]        in_rt_i,
   input  logic [4:0]        in_rd_i,
   input  logic [4:0]        in_sa_i,
   input  logic [5:0]        in_funct_i,
   input  logic [15:0]       in_imm_i,
   input  logic [25:0]       in_index_i,
   input  logic [19:0]       in_code_i,
   input  logic [2:0]        in_sel_i,
   output logic              mem_en_o,
   output logic [3:0]        mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              fmt_err_o,
`ifdef INST_WRITER_CHECKSUM_EN
   output logic [31:0]       checksum_o,
`endif
   output logic [15:0]       words_written_o
);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, mem_addr_q;
   logic [31:0]       mem_wdata_q, enc_word, fifo_rdata;
   logic [31:0]       op_f, rs_f, rt_f, rd_f, funct_f;
   logic [15:0]       words_q;
   logic              mem_en_q, fmt_err_q;
   logic              fifo_full, fifo_empty;
   logic              start_sess, accept, legal, push, pop;

   assign start_sess = (state_q == StIdle) && start_i;
   assign in_ready_o = (state_q == StRun) && !fifo_full;
   assign accept     = in_valid_i && in_ready_o;
   assign legal      = fmt_legal(in_fmt_i);
   assign push       = accept && legal;
   assign pop        = ((state_q == StRun) || (state_q == StDrain)) && !fifo_empty;

   assign op_f    = 32'(in_opcode_i) << OP_LSB;
   assign rs_f    = 32'(in_rs_i) << RS_LSB;
   assign rt_f    = 32'(in_rt_i) << RT_LSB;
   assign rd_f    = 32'(in_rd_i) << RD_LSB;
   assign funct_f = 32'(in_funct_i);

   always_comb begin
      enc_word = '0;
      case (in_fmt_i)
         FMT_R:    enc_word = op_f | rs_f | rt_f | rd_f | (32'(in_sa_i) << SA_LSB) | funct_f;
         FMT_I:    enc_word = op_f | rs_f | rt_f | 32'(in_imm_i);
         FMT_J:    enc_word = op_f | 32'(in_index_i);
         FMT_CODE: enc_word = op_f | (32'(in_code_i) << CODE_LSB) | funct_f;
         FMT_COP:  enc_word = op_f | rs_f | rt_f | rd_f | 32'(in_sel_i);
         default:  enc_word = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_sess) state_d = StRun;
         StRun:   if (accept && in_last_i) state_d = StDrain;
         StDrain: if (fifo_empty) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   sync_fifo #(
      .Width (32),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .push_i   (push),
      .wdata_i  (enc_word),
      .pop_i    (pop),
      .rdata_o  (fifo_rdata),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   // Pops never happen in IDLE, so a session start cannot collide with a pointer bump.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         fmt_err_q   <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q  <= state_d;
         mem_en_q <= pop;
         if (pop) begin
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= fifo_rdata;
            ptr_q       <= ptr_q + ADDR_W'(4);
         end
         if (start_sess) begin
            ptr_q     <= {base_addr_i[ADDR_W-1:2], 2'b00};
            fmt_err_q <= 1'b0;
            words_q   <= '0;
         end else begin
            if (accept && !legal) fmt_err_q <= 1'b1;
            if (pop && (words_q != 16'hffff)) words_q <= words_q + 16'd1;
         end
      end
   end

`ifdef INST_WRITER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i)       checksum_q <= '0;
      else if (start_sess) checksum_q <= '0;
      else if (pop)        checksum_q <= checksum_q ^ fifo_rdata;
   end

   assign checksum_o = checksum_q;
`endif

   assign mem_en_o        = mem_en_q;
   assign mem_wen_o       = mem_en_q ? 4'hf : 4'h0;
   assign mem_addr_o      = mem_addr_q;
   assign mem_wdata_o     = mem_wdata_q;
   assign busy_o          = (state_q != StIdle);
   assign done_o          = (state_q == StDone);
   assign fmt_err_o       = fmt_err_q;
   assign words_written_o = words_q;

endmodule

// File: doc/inst_stream_writer.md
Name: inst_stream_writer

Overview:
Encoder and writer counterpart of the ID-stage field decoder. It accepts per-instruction field bundles (opcode, rs, rt, rd, sa, funct, imm, instIndex, code, sel) over a valid/ready stream and packs each into a 32-bit MIPS word. Words are buffered in a small FIFO and streamed into instruction RAM through its synchronous write port at consecutive word addresses. Used by the boot/test loader to fill instruction memory before the CPU is released.

Parameters:
ADDR_W, 32, byte-address width of the instruction RAM port
FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session (ignored unless IDLE)
base_addr  input  ADDR_W  first byte address, sampled on start; bits[1:0] forced to 0
in_valid  input  1  field bundle valid
in_ready  output  1  bundle accepted when in_valid&&in_ready
in_last  input  1  marks final bundle of the session
in_fmt  input  3  0=R, 1=I, 2=J, 3=CODE, 4=COP; 5..7 illegal
in_opcode  input  6  [31:26]
in_rs  input  5  [25:21]
in_rt  input  5  [20:16]
in_rd  input  5  [15:11]
in_sa  input  5  [10:6]
in_funct  input  6  [5:0]
in_imm  input  16  [15:0]
in_index  input  26  [25:0]
in_code  input  20  [25:6]
in_sel  input  3  [2:0]
mem_en  output  1  RAM write strobe
mem_wen  output  4  byte enables, 4'hf when mem_en else 4'h0
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  32  encoded word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at session end
fmt_err  output  1  sticky; illegal in_fmt seen this session
words_written  output  16  words written this session, saturating

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0, address pointer 0.
- Encoding (combinational on accepted beat): R = {op,rs,rt,rd,sa,funct}; I = {op,rs,rt,imm}; J = {op,index}; CODE = {op,code,funct}; COP = {op,rs,rt,rd,8'b0,sel}. Unused inputs ignored.
- States: IDLE -> RUN on start (latch base_addr into pointer, clear fmt_err, words_written). RUN -> DRAIN on accepted beat with in_last. DRAIN -> DONE when FIFO empty and no write pending. DONE -> IDLE next cycle; done=1 only in DONE.
- in_ready = (state==RUN) && !fifo_full. Ready depends only on registered state, not on same-cycle pop.
- Accepted legal beat pushes encoded word. Illegal fmt: beat consumed, nothing pushed, fmt_err set. in_last honoured even on an illegal beat.
- Write side, RUN or DRAIN: when FIFO non-empty, pop one word per cycle. mem_en/mem_addr/mem_wdata are registered outputs valid the cycle after the pop. Pointer += 4, wrapping modulo 2^ADDR_W. RAM always accepts.
- Latency: bundle accepted in cycle N appears on mem_* in cycle N+2 when FIFO was empty.
- Simultaneous push and pop are allowed; occupancy is unchanged.
- start while busy is ignored. resetn low mid-session aborts immediately with no done. Partial writes already issued stand.
- Empty session not possible: the session ends only on in_last.

Optional Feature:
INST_WRITER_CHECKSUM_EN: adds output checksum[31:0], the running XOR of every mem_wdata written, cleared on start and held after done. Without the macro, port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header inst_fmt_pkg: fmt code constants (FMT_R..FMT_COP), field bit-position constants, state encodings.
- One sub-module: sync_fifo (parameterised width/depth, full/empty, simultaneous push/pop). Encoder stays inline.

Test Plan:
- start base_addr=0x100, R addu rs=1 rt=2 rd=3 funct=0x21 with last -> mem write 0x00221821 at 0x100, done one cycle later, words_written=1.
- I addiu op=9 rs=1 rt=2 imm=5, then J op=2 index=0x0100000 last -> 0x24220005 @base, 0x08100000 @base+4.
- COP op=0x10 rt=8 rd=12 sel=0 -> 0x40086000; CODE op=0 code=0xABCDE funct=0x0D -> 0x02AF378D.
- in_valid held high for 10 beats, FIFO_DEPTH=4 -> in_ready stays high, one write/cycle, no loss, address increments by 4; base_addr=0xFFFFFFF8 wraps to 0x0 on the 3rd word.
- fmt=6 mid-stream -> no write for that beat, fmt_err=1, following words at contiguous addresses; next start clears fmt_err.
- resetn asserted during DRAIN with 3 words queued -> outputs 0 immediately, no done, IDLE after release; a new start works normally.
